// File: rtl/ro_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the ring-oscillator bank meter.
// Holds the measurement FSM state encoding, the fixed arm time and the select-width helper.
package ro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int ARM_CYCLES = 8;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/inv.sv
`timescale 1ns/1ps
// Single inverter cell, the library primitive the rings are built from.
// Purely combinational; no latency, no flow control.
module inv (
    input  logic a,
    output logic y
);

    assign y = ~a;

endmodule

// File: rtl/ro_cell.sv
`timescale 1ns/1ps
// One gated ring oscillator: an AND gate closes the loop through N_STAGES inverters.
// Output is the gated node, so a disabled ring rests at 0 whatever phase it stopped in.
module ro_cell #(
    parameter int N_STAGES = 3
) (
    input  logic en,
    output logic ro
);

    if ((N_STAGES < 3) || ((N_STAGES % 2) == 0)) begin : g_bad_stages
        $error("ro_cell: N_STAGES must be odd and >= 3");
    end

    (* keep *) logic [N_STAGES:0] chain;

    assign chain[0] = en & chain[N_STAGES];
    assign ro       = chain[0];

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        (* keep *) logic y_inv;
        (* keep *) logic y_dly;

        inv u_inv (
            .a (chain[k]),
            .y (y_inv)
        );

`ifndef SYNTHESIS
        // Behavioural gate delay so the loop has a finite period in simulation.
        assign #1 y_dly = y_inv;
`else
        assign y_dly = y_inv;
`endif
        assign chain[k+1] = y_dly;
    end

endmodule

// File: rtl/ro_bank_meter.sv
`timescale 1ns/1ps
// Bank of gated ring oscillators with a gated frequency counter on one selected ring.
// Result after 9+gate_cycles clk cycles; no backpressure, start is ignored while busy.
module ro_bank_meter
    import ro_pkg::*;
#(
    parameter int  N_RO     = 190,
    parameter int  N_STAGES = 3,
    parameter int  PRESC_W  = 4,
    parameter int  GATE_W   = 16,
    parameter int  CNT_W    = 24,
    localparam int SEL_W    = sel_w(N_RO)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SEL_W-1:0]  sel,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              heat_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              err,
    output logic              ro_or
);

    localparam int TMR_W = (GATE_W > 3) ? GATE_W : 3;

    state_e            state_q;
    logic [TMR_W-1:0]  tmr_q;
    logic [SEL_W-1:0]  sel_q;
    logic [GATE_W-1:0] gate_q;
    logic              err_run_q;
    logic              fsm_en_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              ovf_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              sat_q;
    logic              sat_d;
    logic              sel_ok;
    logic              last_tick;

    logic [N_RO-1:0]    fsm_sel;
    logic [N_RO-1:0]    ring_en;
    logic [N_RO-1:0]    ring_out;
    logic               ro_clk;
    logic               presc_clr_n;
    logic [PRESC_W-1:0] presc_q;
    logic [1:0]         sync_q;
    logic               prev_q;
    logic               rise;

    assign sel_ok = ({1'b0, sel} < (SEL_W+1)'(N_RO));

    for (genvar i = 0; i < N_RO; i++) begin : g_ro
        assign fsm_sel[i] = fsm_en_q && (sel_q == SEL_W'(i));
        assign ring_en[i] = heat_en | fsm_sel[i];

        ro_cell #(
            .N_STAGES (N_STAGES)
        ) u_cell (
            .en (ring_en[i]),
            .ro (ring_out[i])
        );
    end

    assign ro_or  = |ring_out;
    assign ro_clk = |(ring_out & fsm_sel);

    // The prescaler only runs while this measurement owns the ring; otherwise it is held at 0.
    assign presc_clr_n = rst_n & fsm_en_q;

    always_ff @(posedge ro_clk or negedge presc_clr_n) begin
        if (!presc_clr_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], presc_q[PRESC_W-1]};
            prev_q <= sync_q[1];
        end
    end

    assign rise = sync_q[1] & ~prev_q;

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if ((state_q == ST_GATE) && rise) begin
            if (cnt_q == '1) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // A zero-length gate goes straight from the last ARM cycle to DONE.
    assign last_tick = (tmr_q == '0) &&
                       (((state_q == ST_ARM) && (gate_q == '0)) || (state_q == ST_GATE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tmr_q     <= '0;
            sel_q     <= '0;
            gate_q    <= '0;
            err_run_q <= 1'b0;
            fsm_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_ARM;
                        tmr_q     <= TMR_W'(ARM_CYCLES - 1);
                        sel_q     <= sel;
                        gate_q    <= gate_cycles;
                        err_run_q <= ~sel_ok;
                        fsm_en_q  <= sel_ok;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        sat_q     <= 1'b0;
                    end
                end
                ST_ARM: begin
                    if (tmr_q == '0) begin
                        if (gate_q != '0) begin
                            state_q <= ST_GATE;
                            tmr_q   <= TMR_W'(gate_q) - TMR_W'(1);
                        end
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                ST_GATE: begin
                    if (tmr_q != '0) begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            if (last_tick) begin
                state_q  <= ST_DONE;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                fsm_en_q <= 1'b0;
                count_q  <= cnt_d;
                ovf_q    <= sat_d;
                err_q    <= err_run_q;
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ro_bank_meter.sv
`timescale 1ns/1ps
// Self-checking bench for ro_bank_meter: scoreboard of expected results popped on each done.
module tb_ro_bank_meter;

    localparam int N_RO   = 190;
    localparam int SEL_W  = 8;
    localparam int GATE_W = 16;
    localparam int CNT_W  = 24;

    logic              clk         = 1'b0;
    logic              rst_n       = 1'b0;
    logic              start       = 1'b0;
    logic [SEL_W-1:0]  sel         = '0;
    logic [GATE_W-1:0] gate_cycles = '0;
    logic              heat_en     = 1'b0;
    logic              busy, done, overflow, err, ro_or;
    logic [CNT_W-1:0]  count;

    logic              s_start   = 1'b0;
    logic [1:0]        s_sel     = '0;
    logic [GATE_W-1:0] s_gate    = '0;
    logic              s_busy, s_done, s_overflow, s_err, s_ro_or;
    logic [3:0]        s_count;

    ro_bank_meter #(
        .N_RO (N_RO), .N_STAGES (3), .PRESC_W (4), .GATE_W (GATE_W), .CNT_W (CNT_W)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .sel (sel),
        .gate_cycles (gate_cycles), .heat_en (heat_en), .busy (busy), .done (done),
        .count (count), .overflow (overflow), .err (err), .ro_or (ro_or)
    );

    ro_bank_meter #(
        .N_RO (4), .N_STAGES (3), .PRESC_W (4), .GATE_W (GATE_W), .CNT_W (4)
    ) dut_small (
        .clk (clk), .rst_n (rst_n), .start (s_start), .sel (s_sel),
        .gate_cycles (s_gate), .heat_en (1'b0), .busy (s_busy), .done (s_done),
        .count (s_count), .overflow (s_overflow), .err (s_err), .ro_or (s_ro_or)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ro_tog = 0;
    always @(ro_or) ro_tog++;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int done_cyc;
        int lo;
        int hi;
        bit ovf;
        bit err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_exp  = 0;
    int   n_done = 0;
    logic prev_busy = 1'b0;
    int   last_lo = 0;
    int   last_hi = 0;

    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle", cyc, mon_e.done_cyc);
                check("busy_at_done", busy, 0);
                check("busy_before_done", prev_busy, 1);
                check($sformatf("count_%0d..%0d_got_%0d", mon_e.lo, mon_e.hi, count),
                      (count >= CNT_W'(mon_e.lo)) && (count <= CNT_W'(mon_e.hi)), 1);
                check("overflow", overflow, mon_e.ovf);
                check("err", err, mon_e.err);
                last_lo = mon_e.lo;
                last_hi = mon_e.hi;
            end
        end
        prev_busy = busy;
    end

    // Ring period 6 ns, /16 prescaler -> one counted edge per 96 ns of a 10 ns clk gate.
    task automatic do_meas(input int s, input int g, input int n_extra);
        exp_t e;
        int   nom;
        int   gap;
        @(negedge clk);
        sel         = SEL_W'(s);
        gate_cycles = GATE_W'(g);
        start       = 1'b1;
        e.done_cyc  = cyc + 9 + g;
        e.err       = (s >= N_RO);
        e.ovf       = 1'b0;
        if (e.err || g == 0) begin
            e.lo = 0;
            e.hi = 0;
        end else begin
            nom  = (g * 10) / 96;
            e.lo = nom - 1;
            e.hi = nom + 1;
        end
        sb.push_back(e);
        n_exp++;
        @(negedge clk);
        start = 1'b0;
        check("busy_t_plus_1", busy, 1);
        if (n_extra > 0) begin
            gap = (g + 8) / (n_extra + 1) - 1;
            for (int k = 0; k < n_extra; k++) begin
                repeat (gap) @(negedge clk);
                start       = 1'b1;
                sel         = SEL_W'(9);
                gate_cycles = GATE_W'(5);
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t_exp;
        int n;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_err", err, 0);
        check("rst_ro_or", ro_or, 0);
        check("rst_small_ro_or", s_ro_or, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal measurement on ring 5
        ro_tog = 0;
        do_meas(5, 1000, 0);
        wait_drain(1200);
        check("ro_or_toggled_sel5", ro_tog > 1000, 1);
        check("ro_or_idle_after", ro_or, 0);
        t0 = ro_tog;
        repeat (20) @(negedge clk);
        check("ro_quiet_after", ro_tog, t0);
        check("done_single_pulse", done, 0);
        check($sformatf("count_hold_got_%0d", count),
              (count >= CNT_W'(last_lo)) && (count <= CNT_W'(last_hi)), 1);

        // Out-of-range selects: no ring runs, err reported
        ro_tog = 0;
        do_meas(200, 50, 0);
        wait_drain(200);
        check("no_toggle_sel200", ro_tog, 0);
        do_meas(190, 20, 0);
        wait_drain(200);
        do_meas(189, 100, 0);
        wait_drain(300);

        // Start pulses while busy are ignored
        do_meas(7, 300, 3);
        wait_drain(500);
        repeat (30) @(negedge clk);

        // Reset in the middle of GATE
        do_meas(11, 500, 0);
        repeat (200) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ro_or", ro_or, 0);
        sb.delete();
        n_exp--;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        do_meas(11, 500, 0);
        wait_drain(700);

        // Heater on: all rings run, timing unchanged
        heat_en = 1'b1;
        repeat (3) @(negedge clk);
        ro_tog = 0;
        do_meas(3, 0, 0);
        wait_drain(100);
        check("heat_ro_or_toggles", ro_tog > 20, 1);
        do_meas(5, 200, 0);
        wait_drain(300);
        heat_en = 1'b0;
        repeat (3) @(negedge clk);

        // Narrow counter saturates
        @(negedge clk);
        s_sel   = 2'd1;
        s_gate  = GATE_W'(1000);
        s_start = 1'b1;
        t_exp   = cyc + 9 + 1000;
        @(negedge clk);
        s_start = 1'b0;
        check("small_busy", s_busy, 1);
        n = 0;
        while (!s_done && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check("small_done_cycle", cyc, t_exp);
        check("small_count", s_count, 15);
        check("small_overflow", s_overflow, 1);
        check("small_err", s_err, 0);

        repeat (5) @(negedge clk);
        check("done_total", n_done, n_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
